// File: rtl/apb2axi_pkg.sv
// apb2axi_pkg: shared types and AXI encodings for the APB3 -> AXI4 bridge.
//   state_e      bridge FSM states
//   BURST_*      AXI burst encodings
//   SIZE_*       AXI beat size encodings
//   CACHE_*      AXI cache attribute encodings
//   RESP_*       AXI response encodings
//   lane_strb()  byte strobe for the 32-bit lane selected by addr[2]
package apb2axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam logic [1:0] BURST_INCR       = 2'b01;
  localparam logic [2:0] SIZE_4B          = 3'b010;
  localparam logic [3:0] CACHE_MODIFIABLE = 4'b0010;
  localparam logic [1:0] RESP_OKAY        = 2'b00;
  localparam logic [1:0] RESP_SLVERR      = 2'b10;

  // A 32-bit APB word lives in one half of the 64-bit AXI data bus.
  function automatic logic [7:0] lane_strb(input logic hi_word);
    return hi_word ? 8'hF0 : 8'h0F;
  endfunction

endpackage

// File: rtl/apb2axi_32_64_if.sv
// apb2axi_32_64_if: AXI4 five-channel bundle between the bridge and an AXI slave.
//   master modport: used by the bridge (drives AW/W/AR payload+valid, B/R ready)
//   slave modport : used by the AXI slave side (drives readies, B/R payload+valid)
interface apb2axi_32_64_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 16,
  parameter int unsigned USER_W = 10
);

  logic [ID_W-1:0]   aw_id;
  logic [ADDR_W-1:0] aw_addr;
  logic [7:0]        aw_len;
  logic [2:0]        aw_size;
  logic [1:0]        aw_burst;
  logic              aw_lock;
  logic [3:0]        aw_cache;
  logic [2:0]        aw_prot;
  logic [3:0]        aw_region;
  logic [3:0]        aw_qos;
  logic [USER_W-1:0] aw_user;
  logic              aw_valid;
  logic              aw_ready;

  logic [63:0]       w_data;
  logic [7:0]        w_strb;
  logic              w_last;
  logic [USER_W-1:0] w_user;
  logic              w_valid;
  logic              w_ready;

  logic [ID_W-1:0]   b_id;
  logic [1:0]        b_resp;
  logic [USER_W-1:0] b_user;
  logic              b_valid;
  logic              b_ready;

  logic [ID_W-1:0]   ar_id;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic              ar_lock;
  logic [3:0]        ar_cache;
  logic [2:0]        ar_prot;
  logic [3:0]        ar_region;
  logic [3:0]        ar_qos;
  logic [USER_W-1:0] ar_user;
  logic              ar_valid;
  logic              ar_ready;

  logic [ID_W-1:0]   r_id;
  logic [63:0]       r_data;
  logic [1:0]        r_resp;
  logic              r_last;
  logic [USER_W-1:0] r_user;
  logic              r_valid;
  logic              r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_region, aw_qos, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_region, ar_qos, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_region, aw_qos, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_region, ar_qos, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/apb2axi_timeout_cnt.sv
// apb2axi_timeout_cnt: response-wait watchdog.
//   clk_i, rst_ni : clock, async active-low reset
//   load          : clear the count (held while not waiting for a response)
//   en            : count one cycle of waiting
//   expire        : high in the TIMEOUT_CYCLES-th waiting cycle
module apb2axi_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_reg;

  // Count index k means this is the (k+1)-th waiting cycle, so the last
  // allowed cycle is TIMEOUT_CYCLES-1.
  assign expire = en && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= '0;
    end else if (en && !expire) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/apb2axi_32_64.sv
// apb2axi_32_64: APB3 slave to AXI4 master bridge, 32-bit APB data onto a
// 64-bit AXI bus. Each APB transfer becomes one single-beat AXI transaction.
//   clk_i, rst_ni              : clock, async active-low reset
//   psel_i/penable_i/pwrite_i  : APB control
//   paddr_i, pwdata_i          : APB address / write data
//   prdata_o, pready_o,
//   pslverr_o                  : APB completion (pready is one cycle in DONE)
//   axi                        : AXI4 master channels (apb2axi_32_64_if.master)
module apb2axi_32_64
  import apb2axi_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_USER_WIDTH = 10,
  parameter int unsigned AXI_ID_VALUE   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [AXI_ADDR_WIDTH-1:0] paddr_i,
  input  logic [31:0]               pwdata_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  apb2axi_32_64_if.master           axi
);

  state_e                    state_reg, state_next;
  logic [AXI_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [31:0]               wdata_reg, wdata_next;
  logic [31:0]               rdata_reg, rdata_next;
  logic [1:0]                resp_reg, resp_next;
  logic                      aw_done_reg, aw_done_next;
  logic                      w_done_reg, w_done_next;

  logic                      aw_valid, w_valid, ar_valid, b_ready, r_ready;
  logic                      to_en, to_expire;
  logic [AXI_ADDR_WIDTH-1:0] axi_addr;

  apb2axi_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .load  (!to_en),
    .en    (to_en),
    .expire(to_expire)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      resp_reg    <= '0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      rdata_reg   <= rdata_next;
      resp_reg    <= resp_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    rdata_next   = rdata_reg;
    resp_next    = resp_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;

    // AW and W complete independently; each valid drops once its own
    // handshake has been recorded.
    aw_valid  = (state_reg == WR_REQ) && !aw_done_reg;
    w_valid   = (state_reg == WR_REQ) && !w_done_reg;
    ar_valid  = (state_reg == RD_REQ);
    // Ready also stays high in IDLE so a response that arrives after a
    // timeout is drained instead of stalling the slave.
    b_ready   = (state_reg == IDLE) || (state_reg == WR_RESP);
    r_ready   = (state_reg == IDLE) || (state_reg == RD_RESP);
    to_en     = (state_reg == WR_RESP) || (state_reg == RD_RESP);
    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    prdata_o  = '0;

    case (state_reg)
      IDLE: begin
        if (psel_i && penable_i) begin
          addr_next    = paddr_i;
          wdata_next   = pwdata_i;
          rdata_next   = '0;
          resp_next    = RESP_OKAY;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = pwrite_i ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        if (aw_valid && axi.aw_ready) aw_done_next = 1'b1;
        if (w_valid && axi.w_ready)   w_done_next  = 1'b1;
        if (aw_done_next && w_done_next) state_next = WR_RESP;
      end
      WR_RESP: begin
        if (axi.b_valid) begin
          resp_next  = axi.b_resp;
          state_next = DONE;
        end else if (to_expire) begin
          resp_next  = RESP_SLVERR;
          state_next = DONE;
        end
      end
      RD_REQ: begin
        if (axi.ar_ready) state_next = RD_RESP;
      end
      RD_RESP: begin
        if (axi.r_valid) begin
          resp_next  = axi.r_resp;
          rdata_next = addr_reg[2] ? axi.r_data[63:32] : axi.r_data[31:0];
          state_next = DONE;
        end else if (to_expire) begin
          resp_next  = RESP_SLVERR;
          state_next = DONE;
        end
      end
      DONE: begin
        pready_o   = 1'b1;
        pslverr_o  = resp_reg[1];
        prdata_o   = rdata_reg;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // AXI addresses are always 32-bit word aligned.
  assign axi_addr = {addr_reg[AXI_ADDR_WIDTH-1:2], 2'b00};

  assign axi.aw_id     = AXI_ID_WIDTH'(AXI_ID_VALUE);
  assign axi.aw_addr   = axi_addr;
  assign axi.aw_len    = 8'd0;
  assign axi.aw_size   = SIZE_4B;
  assign axi.aw_burst  = BURST_INCR;
  assign axi.aw_lock   = 1'b0;
  assign axi.aw_cache  = CACHE_MODIFIABLE;
  assign axi.aw_prot   = 3'b000;
  assign axi.aw_region = 4'd0;
  assign axi.aw_qos    = 4'd0;
  assign axi.aw_user   = '0;
  assign axi.aw_valid  = aw_valid;

  // The APB word is replicated into both halves; the strobe picks the lane.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_wlane
      assign axi.w_data[gi*32 +: 32] = wdata_reg;
    end
  endgenerate
  assign axi.w_strb  = lane_strb(addr_reg[2]);
  assign axi.w_last  = 1'b1;
  assign axi.w_user  = '0;
  assign axi.w_valid = w_valid;

  assign axi.b_ready = b_ready;

  assign axi.ar_id     = AXI_ID_WIDTH'(AXI_ID_VALUE);
  assign axi.ar_addr   = axi_addr;
  assign axi.ar_len    = 8'd0;
  assign axi.ar_size   = SIZE_4B;
  assign axi.ar_burst  = BURST_INCR;
  assign axi.ar_lock   = 1'b0;
  assign axi.ar_cache  = CACHE_MODIFIABLE;
  assign axi.ar_prot   = 3'b000;
  assign axi.ar_region = 4'd0;
  assign axi.ar_qos    = 4'd0;
  assign axi.ar_user   = '0;
  assign axi.ar_valid  = ar_valid;

  assign axi.r_ready = r_ready;

  // IDs, user fields and r_last carry no information for single-beat
  // transfers with a fixed ID.
  logic unused_inputs;
  assign unused_inputs = ^{addr_reg[1:0], resp_reg[0], axi.b_id, axi.b_user,
                           axi.r_id, axi.r_last, axi.r_user};

endmodule

// File: tb/tb_apb2axi_32_64.sv
module tb_apb2axi_32_64;

  localparam int AW  = 32;
  localparam int IDW = 16;
  localparam int UW  = 10;
  localparam int TO  = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;

  always #5 clk = ~clk;

  apb2axi_32_64_if #(.ADDR_W(AW), .ID_W(IDW), .USER_W(UW)) axi ();

  apb2axi_32_64 #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_ID_WIDTH  (IDW),
    .AXI_USER_WIDTH(UW),
    .AXI_ID_VALUE  (0),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .psel_i   (psel),
    .penable_i(penable),
    .pwrite_i (pwrite),
    .paddr_i  (paddr),
    .pwdata_i (pwdata),
    .prdata_o (prdata),
    .pready_o (pready),
    .pslverr_o(pslverr),
    .axi      (axi)
  );

  // ---------------- AXI slave model ----------------
  logic        s_aw_ready = 1'b0, s_w_ready = 1'b0, s_ar_ready = 1'b0;
  logic        s_b_valid = 1'b0, s_r_valid = 1'b0;
  logic [1:0]  s_b_resp = 2'b00, s_r_resp = 2'b00;
  logic [63:0] s_r_data = '0;

  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  b_resp_k = 2'b00, r_resp_k = 2'b00;
  logic [63:0] r_data_k = '0;
  int          b_taken = 0;

  assign axi.aw_ready = s_aw_ready;
  assign axi.w_ready  = s_w_ready;
  assign axi.ar_ready = s_ar_ready;
  assign axi.b_valid  = s_b_valid;
  assign axi.b_resp   = s_b_resp;
  assign axi.b_id     = '0;
  assign axi.b_user   = '0;
  assign axi.r_valid  = s_r_valid;
  assign axi.r_resp   = s_r_resp;
  assign axi.r_data   = s_r_data;
  assign axi.r_id     = '0;
  assign axi.r_last   = 1'b1;
  assign axi.r_user   = '0;

  initial begin
    int   aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic aw_got, w_got, ar_got;
    logic aw_v_s, w_v_s, ar_v_s, b_rdy_s, r_rdy_s;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_got = 0; w_got = 0; ar_got = 0;
    aw_v_s = 0; w_v_s = 0; ar_v_s = 0; b_rdy_s = 0; r_rdy_s = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        s_aw_ready = 0; s_w_ready = 0; s_ar_ready = 0; s_b_valid = 0; s_r_valid = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
      end else begin
        if (aw_v_s && s_aw_ready) aw_got = 1;
        if (w_v_s && s_w_ready)   w_got  = 1;
        if (ar_v_s && s_ar_ready) ar_got = 1;
        if (s_b_valid && b_rdy_s) begin s_b_valid = 0; b_taken++; end
        if (s_r_valid && r_rdy_s) s_r_valid = 0;
        if (axi.aw_valid) begin s_aw_ready = (aw_cnt >= aw_delay); aw_cnt++; end
        else begin s_aw_ready = 0; aw_cnt = 0; end
        if (axi.w_valid) begin s_w_ready = (w_cnt >= w_delay); w_cnt++; end
        else begin s_w_ready = 0; w_cnt = 0; end
        if (axi.ar_valid) begin s_ar_ready = (ar_cnt >= ar_delay); ar_cnt++; end
        else begin s_ar_ready = 0; ar_cnt = 0; end
        if (aw_got && w_got) begin
          if (b_cnt >= b_delay) begin
            s_b_valid = 1; s_b_resp = b_resp_k; aw_got = 0; w_got = 0; b_cnt = 0;
          end else b_cnt++;
        end
        if (ar_got) begin
          if (r_cnt >= r_delay) begin
            s_r_valid = 1; s_r_resp = r_resp_k; s_r_data = r_data_k; ar_got = 0; r_cnt = 0;
          end else r_cnt++;
        end
      end
      aw_v_s = axi.aw_valid; w_v_s = axi.w_valid; ar_v_s = axi.ar_valid;
      b_rdy_s = axi.b_ready; r_rdy_s = axi.r_ready;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed { logic [31:0] rdata; logic err; } apb_exp_t;
  typedef struct packed { logic [63:0] data; logic [7:0] strb; } w_exp_t;

  apb_exp_t    apb_q[$];
  logic [31:0] aw_q[$];
  w_exp_t      w_q[$];
  logic [31:0] ar_q[$];

  int total = 0;
  int bad   = 0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0, aw_vcyc = 0, w_vcyc = 0;

  // Single-beat INCR, 4-byte size, modifiable cache, everything else zero.
  localparam logic [58:0] CONST_EXP = {16'h0, 8'd0, 3'b010, 2'b01, 1'b0, 4'b0010,
                                       3'b000, 4'd0, 4'd0, 10'd0};

  initial begin
    logic     pready_prev;
    apb_exp_t e;
    w_exp_t   we;
    logic [31:0] ea;
    pready_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (pready) begin
          total++;
          if (pready_prev) begin
            bad++;
            $display("FAIL pready_width: pready high in consecutive cycles, required one cycle");
          end
          total++;
          if (apb_q.size() == 0) begin
            bad++;
            $display("FAIL apb_unexpected: pready with prdata=%h pslverr=%b, required none", prdata, pslverr);
          end else begin
            e = apb_q.pop_front();
            if (prdata !== e.rdata || pslverr !== e.err) begin
              bad++;
              $display("FAIL apb_resp: prdata=%h pslverr=%b, required prdata=%h pslverr=%b",
                       prdata, pslverr, e.rdata, e.err);
            end else begin
              $display("apb done: prdata=%h pslverr=%b", prdata, pslverr);
            end
          end
        end
        if (axi.aw_valid) aw_vcyc++;
        if (axi.w_valid)  w_vcyc++;
        if (axi.aw_valid && axi.aw_ready) begin
          aw_hs++;
          total++;
          if (aw_q.size() == 0) begin
            bad++; $display("FAIL aw_unexpected: aw_addr=%h", axi.aw_addr);
          end else begin
            ea = aw_q.pop_front();
            if (axi.aw_addr !== ea) begin
              bad++; $display("FAIL aw_addr: got %h, required %h", axi.aw_addr, ea);
            end
          end
          total++;
          if ({axi.aw_id, axi.aw_len, axi.aw_size, axi.aw_burst, axi.aw_lock, axi.aw_cache,
               axi.aw_prot, axi.aw_region, axi.aw_qos, axi.aw_user} !== CONST_EXP) begin
            bad++; $display("FAIL aw_attr: len=%h size=%b burst=%b cache=%b, required fixed single-beat attributes",
                            axi.aw_len, axi.aw_size, axi.aw_burst, axi.aw_cache);
          end
        end
        if (axi.w_valid && axi.w_ready) begin
          w_hs++;
          total++;
          if (w_q.size() == 0) begin
            bad++; $display("FAIL w_unexpected: w_data=%h", axi.w_data);
          end else begin
            we = w_q.pop_front();
            if (axi.w_data !== we.data || axi.w_strb !== we.strb || axi.w_last !== 1'b1 || axi.w_user !== '0) begin
              bad++; $display("FAIL w_beat: data=%h strb=%h last=%b, required data=%h strb=%h last=1",
                              axi.w_data, axi.w_strb, axi.w_last, we.data, we.strb);
            end
          end
        end
        if (axi.ar_valid && axi.ar_ready) begin
          ar_hs++;
          total++;
          if (ar_q.size() == 0) begin
            bad++; $display("FAIL ar_unexpected: ar_addr=%h", axi.ar_addr);
          end else begin
            ea = ar_q.pop_front();
            if (axi.ar_addr !== ea) begin
              bad++; $display("FAIL ar_addr: got %h, required %h", axi.ar_addr, ea);
            end
          end
          total++;
          if ({axi.ar_id, axi.ar_len, axi.ar_size, axi.ar_burst, axi.ar_lock, axi.ar_cache,
               axi.ar_prot, axi.ar_region, axi.ar_qos, axi.ar_user} !== CONST_EXP) begin
            bad++; $display("FAIL ar_attr: len=%h size=%b burst=%b cache=%b, required fixed single-beat attributes",
                            axi.ar_len, axi.ar_size, axi.ar_burst, axi.ar_cache);
          end
        end
      end
      pready_prev = rst_n ? pready : 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Runs one APB transfer; returns the number of ACCESS cycles up to and
  // including the one with pready.
  task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_addr, input logic [7:0] exp_strb,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          output int acc);
    apb_exp_t e;
    w_exp_t   we;
    logic     done;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    apb_q.push_back(e);
    if (wr) begin
      aw_q.push_back(exp_addr);
      we.data = {d, d};
      we.strb = exp_strb;
      w_q.push_back(we);
    end else begin
      ar_q.push_back(exp_addr);
    end
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = wr ? d : 32'h0;
    @(posedge clk); #1;
    penable = 1;
    acc  = 0;
    done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      acc++;
      if (pready) done = 1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL apb_wait: no pready within 500 cycles for addr %h", a);
    end
    @(posedge clk); #1;
    psel = 0; penable = 0;
  endtask

  task automatic check_reset_outputs(input string name);
    check_vec(name,
              64'({pready, pslverr, prdata, axi.aw_valid, axi.w_valid, axi.ar_valid,
                   axi.b_ready, axi.r_ready}),
              64'({1'b0, 1'b0, 32'h0, 3'b000, 2'b11}));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acc, snap_aw, snap_w, snap_awv, snap_wv, snap_b, snap_ar;
    logic got;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Write to the high lane with everything ready: minimum latency.
    apb_xfer(1, 32'h1000_0004, 32'hDEAD_BEEF, 32'h1000_0004, 8'hF0, 32'h0, 0, acc);
    check_int("wr_min_latency", acc, 4);

    // Low lane write answered with SLVERR.
    b_resp_k = 2'b10;
    apb_xfer(1, 32'h1000_0000, 32'h1234_5678, 32'h1000_0000, 8'h0F, 32'h0, 1, acc);
    // Unaligned address, DECERR response.
    b_resp_k = 2'b11;
    apb_xfer(1, 32'h4000_0007, 32'hCAFE_F00D, 32'h4000_0004, 8'hF0, 32'h0, 1, acc);
    b_resp_k = 2'b00;

    // Reads selecting each lane.
    r_data_k = 64'h1111_2222_3333_4444;
    apb_xfer(0, 32'h2000_0000, 32'h0, 32'h2000_0000, 8'h00, 32'h3333_4444, 0, acc);
    check_int("rd_min_latency", acc, 4);
    apb_xfer(0, 32'h2000_0004, 32'h0, 32'h2000_0004, 8'h00, 32'h1111_2222, 0, acc);
    apb_xfer(0, 32'h2000_000B, 32'h0, 32'h2000_0008, 8'h00, 32'h3333_4444, 0, acc);

    // Read returning SLVERR.
    r_data_k = 64'hAAAA_BBBB_CCCC_DDDD;
    r_resp_k = 2'b10;
    apb_xfer(0, 32'h3000_0004, 32'h0, 32'h3000_0004, 8'h00, 32'hAAAA_BBBB, 1, acc);
    r_resp_k = 2'b00;

    // AW accepted three cycles late, W immediately.
    snap_aw = aw_hs; snap_w = w_hs; snap_awv = aw_vcyc; snap_wv = w_vcyc;
    aw_delay = 3;
    apb_xfer(1, 32'h6000_0000, 32'h0BAD_C0DE, 32'h6000_0000, 8'h0F, 32'h0, 0, acc);
    aw_delay = 0;
    check_int("aw_valid_cycles", aw_vcyc - snap_awv, 4);
    check_int("w_valid_cycles", w_vcyc - snap_wv, 1);
    check_int("aw_handshakes", aw_hs - snap_aw, 1);
    check_int("w_handshakes", w_hs - snap_w, 1);
    check_int("aw_delay_latency", acc, 7);

    // B withheld past the timeout.
    b_delay = TO + 5;
    snap_b  = b_taken;
    apb_xfer(1, 32'h7000_0004, 32'h55AA_55AA, 32'h7000_0004, 8'hF0, 32'h0, 1, acc);
    check_int("timeout_latency", acc, TO + 3);
    check_int("late_b_not_yet", b_taken - snap_b, 0);
    repeat (15) @(negedge clk);
    check_int("late_b_drained", b_taken - snap_b, 1);
    check_vec("late_b_valid_low", 64'(s_b_valid), 64'(1'b0));
    b_delay = 0;
    apb_xfer(1, 32'h7000_0000, 32'h0F0F_0F0F, 32'h7000_0000, 8'h0F, 32'h0, 0, acc);
    check_int("after_timeout_latency", acc, 4);

    // Reset while waiting for R.
    r_delay = 1000;
    ar_q.push_back(32'h5000_0000);
    snap_ar = ar_hs;
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 0; paddr = 32'h5000_0000; pwdata = 32'h0;
    @(posedge clk); #1;
    penable = 1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (ar_hs != snap_ar) got = 1;
    end
    check_int("abort_ar_issued", int'(got), 1);
    repeat (3) @(negedge clk);
    check_vec("rd_resp_b_ready", 64'({axi.b_ready, axi.r_ready}), 64'(2'b01));
    rst_n = 0;
    #1;
    check_reset_outputs("async_reset");
    psel = 0; penable = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    r_delay = 0;
    repeat (2) @(negedge clk);
    apb_xfer(1, 32'h8000_0004, 32'h1357_9BDF, 32'h8000_0004, 8'hF0, 32'h0, 0, acc);
    check_int("post_reset_latency", acc, 4);

    repeat (5) @(negedge clk);
    check_int("queues_empty", apb_q.size() + aw_q.size() + w_q.size() + ar_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
